dispersion_injector: RTL and testbench

//  Injects a synthetic dispersed pulse into a channel-serial power stream (one word per channel, ch 0..N-1 per spectrum).

---
 rtl/dispersion_injector.sv | 174 +++++++++++++++++
 tb/tb_dispersion_injector.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dispersion_injector.sv
// rtl/dispersion_injector.sv - injects a synthetic dispersed pulse into a channel-serial power stream
// Channel k carries the pulse OFF[k]=DMAX-DELAY[k] spectra after injection start, so the dedispersor realigns it.
module dispersion_injector #(
    parameter int N_CHANNELS = 64,
    parameter int DIN_WIDTH  = 26,
    parameter logic [32*N_CHANNELS-1:0] DELAY_ARRAY = {
        32'd118, 32'd116, 32'd114, 32'd112, 32'd110, 32'd108, 32'd106, 32'd105,
        32'd103, 32'd101, 32'd99,  32'd97,  32'd95,  32'd94,  32'd92,  32'd90,
        32'd88,  32'd86,  32'd84,  32'd83,  32'd81,  32'd79,  32'd77,  32'd75,
        32'd73,  32'd71,  32'd70,  32'd68,  32'd66,  32'd64,  32'd62,  32'd60,
        32'd59,  32'd57,  32'd55,  32'd53,  32'd51,  32'd49,  32'd48,  32'd46,
        32'd44,  32'd42,  32'd40,  32'd38,  32'd36,  32'd35,  32'd33,  32'd31,
        32'd29,  32'd27,  32'd25,  32'd24,  32'd22,  32'd20,  32'd18,  32'd16,
        32'd14,  32'd13,  32'd11,  32'd9,   32'd7,   32'd5,   32'd3,   32'd2},
    parameter int PULSE_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 trigger,
    input  logic [DIN_WIDTH-1:0] amplitude,
    output logic [DIN_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_sof,
    output logic                 dout_eof,
    output logic                 busy,
    output logic                 inj_done
);

    localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    function automatic logic [31:0] f_dmax();
        logic [31:0] m;
        m = DELAY_ARRAY[31:0];
        for (int k = 1; k < N_CHANNELS; k++)
            if (DELAY_ARRAY[32*k +: 32] > m) m = DELAY_ARRAY[32*k +: 32];
        return m;
    endfunction

    function automatic logic [31:0] f_dmin();
        logic [31:0] m;
        m = DELAY_ARRAY[31:0];
        for (int k = 1; k < N_CHANNELS; k++)
            if (DELAY_ARRAY[32*k +: 32] < m) m = DELAY_ARRAY[32*k +: 32];
        return m;
    endfunction

    function automatic logic [32*N_CHANNELS-1:0] f_off();
        logic [32*N_CHANNELS-1:0] v;
        logic [31:0] dmax;
        dmax = f_dmax();
        for (int k = 0; k < N_CHANNELS; k++)
            v[32*k +: 32] = dmax - DELAY_ARRAY[32*k +: 32];
        return v;
    endfunction

    localparam logic [31:0]              DMAX    = f_dmax();
    localparam logic [31:0]              DMIN    = f_dmin();
    localparam logic [31:0]              SPAN    = DMAX - DMIN + 32'(PULSE_WIDTH);
    localparam logic [32*N_CHANNELS-1:0] OFF_VEC = f_off();
    localparam logic [CH_W-1:0]          LAST_CH = CH_W'(N_CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_INJECT} state_t;

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [31:0]            spec_q, spec_d;
    logic [DIN_WIDTH-1:0]   amp_q, amp_d;
    logic [DIN_WIDTH-1:0]   dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   sof_q, sof_d;
    logic                   eof_q, eof_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   last_ch;
    logic                   in_inj;
    logic [31:0]            spec_cur;
    logic [31:0]            off_k;
    logic                   hit;
    logic [DIN_WIDTH:0]     sum;
    logic [DIN_WIDTH-1:0]   sat;

    always_comb begin
        last_ch  = (ch_q == LAST_CH);
        // The ch-0 sample that ends ARMED already belongs to injection spectrum 0.
        in_inj   = (state_q == S_INJECT) || ((state_q == S_ARMED) && (ch_q == '0));
        spec_cur = (state_q == S_INJECT) ? spec_q : 32'd0;
        off_k    = OFF_VEC[32*ch_q +: 32];
        hit      = in_inj && (off_k <= spec_cur) &&
                   ({1'b0, spec_cur} < ({1'b0, off_k} + 33'(PULSE_WIDTH)));
        sum      = {1'b0, din} + {1'b0, (hit ? amp_q : {DIN_WIDTH{1'b0}})};
        sat      = sum[DIN_WIDTH] ? {DIN_WIDTH{1'b1}} : sum[DIN_WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        spec_d       = spec_q;
        amp_d        = amp_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        sof_d        = sof_q;
        eof_d        = eof_q;
        done_d       = done_q;
        if (ce) begin
            dout_valid_d = din_valid;
            sof_d        = din_valid && (ch_q == '0);
            eof_d        = din_valid && last_ch;
            done_d       = 1'b0;
            if (din_valid) begin
                dout_d = sat;
                ch_d   = last_ch ? '0 : ch_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_d = S_ARMED;
                        amp_d   = amplitude;
                    end
                end
                S_ARMED, S_INJECT: begin
                    if (din_valid && in_inj) begin
                        if (last_ch && (spec_cur == SPAN - 32'd1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_INJECT;
                            spec_d  = last_ch ? spec_cur + 32'd1 : spec_cur;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            spec_q       <= '0;
            amp_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            spec_q       <= spec_d;
            amp_q        <= amp_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sof   = sof_q;
    assign dout_eof   = eof_q;
    assign busy       = busy_q;
    assign inj_done   = done_q;

endmodule

// File: tb/tb_dispersion_injector.sv
// tb/tb_dispersion_injector.sv - randomized bench for dispersion_injector against a sample-index model
// Two DUTs (PULSE_WIDTH 1 and 2) share one stimulus stream; each has its own model instance.
module tb_dispersion_injector;

    localparam int N  = 4;
    localparam int DW = 26;
    localparam longint MAXV = (64'd1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          trigger = 1'b0;
    logic [DW-1:0] amplitude = '0;

    logic [DW-1:0] dout_w [2];
    logic          valid_w [2];
    logic          sof_w [2];
    logic          eof_w [2];
    logic          busy_w [2];
    logic          done_w [2];

    always #5 clk = ~clk;

    dispersion_injector #(.N_CHANNELS(N), .DIN_WIDTH(DW),
        .DELAY_ARRAY({32'd5, 32'd4, 32'd3, 32'd2}), .PULSE_WIDTH(1)) u_pw1 (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .din_valid(din_valid),
        .trigger(trigger), .amplitude(amplitude), .dout(dout_w[0]),
        .dout_valid(valid_w[0]), .dout_sof(sof_w[0]), .dout_eof(eof_w[0]),
        .busy(busy_w[0]), .inj_done(done_w[0]));

    dispersion_injector #(.N_CHANNELS(N), .DIN_WIDTH(DW),
        .DELAY_ARRAY({32'd5, 32'd4, 32'd3, 32'd2}), .PULSE_WIDTH(2)) u_pw2 (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .din_valid(din_valid),
        .trigger(trigger), .amplitude(amplitude), .dout(dout_w[1]),
        .dout_valid(valid_w[1]), .dout_sof(sof_w[1]), .dout_eof(eof_w[1]),
        .busy(busy_w[1]), .inj_done(done_w[1]));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[pw%0d] t=%0t actual=%0d required=%0d", name, inst + 1, $time, act, exp);
        end
    endtask

    // Reference model: everything is derived from the global valid-sample index.
    int     DEL [N] = '{2, 3, 4, 5};
    int     OFF [N];
    int     PW [2] = '{1, 2};
    int     SPAN [2];
    bit     m_armed [2];
    bit     m_active [2];
    longint m_sc [2];
    longint m_s0 [2];
    longint m_amp [2];
    longint e_dout [2];
    bit     e_valid [2], e_sof [2], e_eof [2], e_busy [2], e_done [2];

    initial begin
        int dmax, dmin;
        dmax = DEL[0];
        dmin = DEL[0];
        for (int k = 1; k < N; k++) begin
            if (DEL[k] > dmax) dmax = DEL[k];
            if (DEL[k] < dmin) dmin = DEL[k];
        end
        for (int k = 0; k < N; k++) OFF[k] = dmax - DEL[k];
        for (int i = 0; i < 2; i++) SPAN[i] = dmax - dmin + PW[i];
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_armed[i] = 0; m_active[i] = 0; m_sc[i] = 0; m_s0[i] = 0; m_amp[i] = 0;
            e_dout[i] = 0; e_valid[i] = 0; e_sof[i] = 0; e_eof[i] = 0;
            e_busy[i] = 0; e_done[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit     idle0;
        bit     inj;
        int     k;
        longint spec, s;
        idle0 = !m_armed[i] && !m_active[i];
        inj = 0;
        k = int'(m_sc[i] % N);
        e_valid[i] = din_valid;
        e_sof[i] = din_valid && (k == 0);
        e_eof[i] = din_valid && (k == N - 1);
        e_done[i] = 0;
        if (din_valid) begin
            if (m_armed[i] && k == 0) begin
                m_armed[i] = 0;
                m_active[i] = 1;
                m_s0[i] = m_sc[i];
            end
            if (m_active[i]) begin
                spec = (m_sc[i] - m_s0[i]) / N;
                inj = (OFF[k] <= spec) && (spec < OFF[k] + PW[i]);
                if (m_sc[i] == m_s0[i] + longint'(SPAN[i]) * N - 1) begin
                    e_done[i] = 1;
                    m_active[i] = 0;
                end
            end
            s = longint'(din) + (inj ? m_amp[i] : 0);
            e_dout[i] = (s > MAXV) ? MAXV : s;
            m_sc[i]++;
        end
        if (idle0 && trigger) begin
            m_armed[i] = 1;
            m_amp[i] = longint'(amplitude);
        end
        e_busy[i] = m_armed[i] || m_active[i];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else if (ce) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("dout", i, longint'(dout_w[i]), e_dout[i]);
                chk("dout_valid", i, longint'(valid_w[i]), longint'(e_valid[i]));
                chk("dout_sof", i, longint'(sof_w[i]), longint'(e_sof[i]));
                chk("dout_eof", i, longint'(eof_w[i]), longint'(e_eof[i]));
                chk("busy", i, longint'(busy_w[i]), longint'(e_busy[i]));
                chk("inj_done", i, longint'(done_w[i]), longint'(e_done[i]));
            end
        end
    end

    // Hand-derived observations of the first directed injection.
    bit t1_on = 0;
    int mch = 0;
    int inj_ch [$];
    int inj_cnt2 = 0;
    int done_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (t1_on) begin
                if (valid_w[0]) begin
                    mch = sof_w[0] ? 0 : mch + 1;
                    if (dout_w[0] == 26'd110) inj_ch.push_back(mch);
                end
                if (valid_w[1] && dout_w[1] == 26'd110) inj_cnt2++;
                if (done_w[0]) done_cnt++;
            end
        end
    end

    task automatic drive(input bit c, input bit v, input longint d, input bit t, input longint a);
        @(negedge clk);
        #1;
        ce = c;
        din_valid = v;
        din = DW'(d);
        trigger = t;
        amplitude = DW'(a);
    endtask

    task automatic run_const(input int cycles, input longint d, input bit toggle);
        for (int n = 0; n < cycles; n++) drive(1, toggle ? n[0] == 0 : 1'b1, d, 0, 0);
    endtask

    initial begin
        rst = 0;
        repeat (3) @(negedge clk);
        chk("reset_dout", 0, longint'(dout_w[0]), 0);
        chk("reset_busy", 0, longint'(busy_w[0]), 0);
        chk("reset_valid", 1, longint'(valid_w[1]), 0);
        #1;
        rst = 1;

        // Continuous din=10, trigger at ch2, amplitude 100
        t1_on = 1;
        run_const(2, 10, 0);
        drive(1, 1, 10, 1, 100);
        run_const(30, 10, 0);
        @(negedge clk);
        t1_on = 0;
        chk("t1_inj_count", 0, longint'(inj_ch.size()), 4);
        if (inj_ch.size() == 4) begin
            chk("t1_inj_ch_s0", 0, longint'(inj_ch[0]), 3);
            chk("t1_inj_ch_s1", 0, longint'(inj_ch[1]), 2);
            chk("t1_inj_ch_s2", 0, longint'(inj_ch[2]), 1);
            chk("t1_inj_ch_s3", 0, longint'(inj_ch[3]), 0);
        end
        chk("t1_inj_count", 1, longint'(inj_cnt2), 8);
        chk("t1_done_count", 0, longint'(done_cnt), 1);

        // Saturation
        drive(1, 1, MAXV - 4, 1, 100);
        run_const(30, MAXV - 4, 0);

        // Valid toggling with a second trigger during injection
        drive(1, 1, 10, 1, 100);
        for (int n = 0; n < 80; n++) drive(1, n[0] == 0, 10, n == 20, 55);

        // Reset mid-injection, then plain pass-through
        drive(1, 1, 10, 1, 100);
        run_const(9, 10, 0);
        @(negedge clk);
        #1;
        rst = 0;
        #2;
        chk("rst_async_dout", 0, longint'(dout_w[0]), 0);
        chk("rst_async_busy", 1, longint'(busy_w[1]), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1;
        run_const(20, 10, 0);

        // ce held low mid-spectrum during an injection
        drive(1, 1, 10, 1, 100);
        run_const(6, 10, 0);
        for (int n = 0; n < 3; n++) drive(0, 1, 77, 1, 9);
        run_const(30, 10, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            longint d;
            d = ($urandom % 4 == 0) ? MAXV - longint'($urandom % 64) : longint'($urandom % (1 << DW));
            drive($urandom % 8 != 0, $urandom % 4 != 0, d, $urandom % 16 == 0,
                  longint'($urandom % (1 << DW)));
            if ($urandom % 700 == 0) begin
                #2;
                rst = 0;
                @(negedge clk);
                #1;
                rst = 1;
            end
        end
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
